// File: rtl/mem_dma_engine_if.sv
// mem_dma_engine_if: command strobe, status and shared memory-bus signals of the DMA engine.
interface mem_dma_engine_if #(parameter int COUNT_WIDTH = 17);
    logic start, mode, abort, bus_request, bus_grant, busy, done;
    logic [16:0] src_addr, dst_addr, address;
    logic [COUNT_WIDTH-1:0] count;
    logic [31:0] fill_data, data_out, data_in;
    logic [3:0] write_en;
    modport master (
        input start, mode, src_addr, dst_addr, count, fill_data, abort, bus_grant, data_in,
        output bus_request, address, data_out, write_en, busy, done
    );
    modport slave (
        output start, mode, src_addr, dst_addr, count, fill_data, abort, bus_grant, data_in,
        input bus_request, address, data_out, write_en, busy, done
    );
endinterface

// File: rtl/mem_dma_engine.sv
// mem_dma_engine: bus-master block copy/fill engine for the Sigma word-addressed memory bus.
module mem_dma_engine #(
    parameter int COUNT_WIDTH = 17
) (
    input logic clock,
    input logic reset,
    mem_dma_engine_if.master bus
);
    localparam logic [2:0] IDLE = 3'd0, REQ = 3'd1, READ = 3'd2, WRITE = 3'd3, FINISH = 3'd4;
    logic [2:0] state, after_word;
    logic mode_q;
    logic [16:0] src_q, dst_q;
    logic [COUNT_WIDTH-1:0] cnt_q;
    logic [31:0] fill_q, hold_q;
    // grant is only re-checked once a word has fully committed
    always_comb after_word = !bus.bus_grant ? REQ : mode_q ? WRITE : READ;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            mode_q <= 1'b0;
            src_q <= '0;
            dst_q <= '0;
            cnt_q <= '0;
            fill_q <= '0;
            hold_q <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    mode_q <= bus.mode;
                    src_q <= bus.src_addr;
                    dst_q <= bus.dst_addr;
                    cnt_q <= bus.count;
                    fill_q <= bus.fill_data;
                    state <= (bus.count == '0) ? FINISH : REQ;
                end
                REQ: state <= bus.abort ? IDLE : bus.bus_grant ? (mode_q ? WRITE : READ) : REQ;
                READ: begin
                    hold_q <= bus.data_in;
                    state <= bus.abort ? IDLE : WRITE;
                end
                WRITE: begin
                    src_q <= src_q + 17'd1;
                    dst_q <= dst_q + 17'd1;
                    cnt_q <= cnt_q - COUNT_WIDTH'(1);
                    state <= bus.abort ? IDLE : (cnt_q == COUNT_WIDTH'(1)) ? FINISH : after_word;
                end
                default: state <= IDLE;
            endcase
        end
    end
    // outputs idle at zero so the bus can be OR-combined with the CPU
    assign bus.busy = state != IDLE;
    assign bus.done = state == FINISH;
    assign bus.bus_request = (state == REQ) || (state == READ) || (state == WRITE);
    assign bus.address = (state == READ) ? src_q : (state == WRITE) ? dst_q : '0;
    assign bus.data_out = (state == WRITE) ? (mode_q ? fill_q : hold_q) : '0;
    assign bus.write_en = {4{state == WRITE}};
endmodule
